bsg_array_elem_sequencer: RTL and testbench

BSG_ARRAY_ELEM_SEQUENCER -- requirements
Module: bsg_array_elem_sequencer

---
 rtl/bsg_array_seq_pkg.sv | 14 +
 rtl/bsg_priority_encode.sv | 18 +
 rtl/bsg_array_elem_sequencer.sv | 100 ++++++++++
 tb/tb_bsg_array_elem_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bsg_array_seq_pkg.sv
// Shared types and helpers for the array element sequencer.
package bsg_array_seq_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int lg_els(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_priority_encode.sv
// Returns the index of the lowest set bit of i; zero when no bit is set.
module bsg_priority_encode #(
  parameter int width_p    = 5,
  parameter int lg_width_p = 3
) (
  input  logic [width_p-1:0]    i,
  output logic [lg_width_p-1:0] addr_o
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    addr_o = '0;
    for (int k = width_p - 1; k >= 0; k--) begin
      if (i[k]) addr_o = lg_width_p'(k);
    end
  end

endmodule

// File: rtl/bsg_array_elem_sequencer.sv
// Accepts a packed array with a per-element mask and streams the selected
// elements out one beat per cycle in ascending index order.
//   state | meaning
//   IDLE  | ready for a new array; no beat offered
//   SEND  | offering element idx_o of the captured array
module bsg_array_elem_sequencer
  import bsg_array_seq_pkg::*;
#(
  parameter  int width_p   = 32,
  parameter  int els_p     = 5,
  localparam int lg_els_lp = lg_els(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  input  logic [width_p*els_p-1:0]   data_i,
  input  logic [els_p-1:0]           mask_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic [lg_els_lp-1:0]       idx_o,
  output logic                       last_o,
  input  logic                       yumi_i
);

  localparam int sel_w_lp = lg_els(width_p * els_p);

  state_e                     state_r, state_n;
  logic [els_p-1:0]           mask_r;
  logic [width_p*els_p-1:0]   data_r;
  logic [els_p-1:0]           cur_bit;
  logic [els_p-1:0]           rest_mask;
  logic [sel_w_lp-1:0]        elem_base;
  logic                       load, take;

  // The mask register is all-zero whenever the block is idle, so idx_o
  // reads zero there without a separate idx register.
  bsg_priority_encode #(
    .width_p   (els_p),
    .lg_width_p(lg_els_lp)
  ) penc (
    .i     (mask_r),
    .addr_o(idx_o)
  );

  always_comb begin
    cur_bit = '0;
    for (int k = 0; k < els_p; k++) begin
      cur_bit[k] = (idx_o == lg_els_lp'(k));
    end
  end

  assign rest_mask = mask_r & ~cur_bit;
  assign elem_base = sel_w_lp'(int'(idx_o) * width_p);
  assign data_o    = data_r[elem_base +: width_p];

  always_comb begin
    state_n = state_r;
    ready_o = 1'b0;
    v_o     = 1'b0;
    last_o  = 1'b0;
    load    = 1'b0;
    take    = 1'b0;
    case (state_r)
      IDLE: begin
        ready_o = 1'b1;
        load    = v_i;
        if (v_i && (mask_i != '0)) state_n = SEND;
      end
      SEND: begin
        v_o    = 1'b1;
        last_o = (rest_mask == '0);
        take   = yumi_i;
        if (yumi_i && (rest_mask == '0)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      mask_r  <= '0;
      data_r  <= '0;
    end else begin
      state_r <= state_n;
      if (load) begin
        mask_r <= mask_i;
        data_r <= data_i;
      end else if (take) begin
        mask_r <= rest_mask;
      end
    end
  end

  yumi_only_when_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o)
  );

endmodule

// File: tb/tb_bsg_array_elem_sequencer.sv
// Directed and randomized checks of the element sequencer against a
// queue-of-beats reference model.
module tb_bsg_array_elem_sequencer;

  localparam int W  = 32;
  localparam int N  = 5;
  localparam int LG = 3;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              v_i;
  logic [W*N-1:0]    data_i;
  logic [N-1:0]      mask_i;
  logic              ready_o;
  logic              v_o;
  logic [W-1:0]      data_o;
  logic [LG-1:0]     idx_o;
  logic              last_o;
  logic              yumi_i;

  bsg_array_elem_sequencer #(.width_p(W), .els_p(N)) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (v_i),
    .data_i (data_i),
    .mask_i (mask_i),
    .ready_o(ready_o),
    .v_o    (v_o),
    .data_o (data_o),
    .idx_o  (idx_o),
    .last_o (last_o),
    .yumi_i (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t q[$];
  int    nvec = 0;
  int    nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp)
    else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("ready_o", 32'(ready_o), 32'(q.size() == 0));
    chk("v_o", 32'(v_o), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("data_o", data_o, q[0].data);
      chk("idx_o", 32'(idx_o), 32'(q[0].idx));
      chk("last_o", 32'(last_o), 32'(q[0].last));
    end else begin
      chk("last_o_idle", 32'(last_o), 32'd0);
    end
  endtask

  // Behaviour at a rising edge: a busy block pops on yumi, an idle one
  // expands an offered array into its selected beats.
  task automatic model_edge(input logic v, input logic [W*N-1:0] d,
                            input logic [N-1:0] m, input logic y);
    if (q.size() != 0) begin
      if (y) void'(q.pop_front());
    end else if (v) begin
      for (int k = 0; k < N; k++) begin
        if (m[k]) begin
          beat_t b;
          b.idx  = k;
          b.data = d[k*W +: W];
          b.last = 1'b0;
          q.push_back(b);
        end
      end
      if (q.size() != 0) q[q.size()-1].last = 1'b1;
    end
  endtask

  // One cycle: drive, check mid-cycle, clock, advance model. yumi is only
  // presented while the model says a beat is on offer.
  task automatic step(input logic v, input logic [W*N-1:0] d,
                      input logic [N-1:0] m, input logic y);
    logic y_eff;
    y_eff  = y && (q.size() != 0);
    v_i    = v;
    data_i = d;
    mask_i = m;
    yumi_i = y_eff;
    @(negedge clk_i);
    check_outputs();
    @(posedge clk_i);
    model_edge(v, d, m, y_eff);
    #1;
  endtask

  function automatic logic [W*N-1:0] rnd_arr();
    logic [W*N-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = $urandom;
    return r;
  endfunction

  logic [W*N-1:0] seq_a0;

  initial begin
    for (int k = 0; k < N; k++) seq_a0[k*W +: W] = 32'hA0 + 32'(k);

    reset_i = 1'b1;
    v_i     = 1'b0;
    data_i  = '0;
    mask_i  = '0;
    yumi_i  = 1'b0;
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_v", 32'(v_o), 32'd0);
    chk("rst_last", 32'(last_o), 32'd0);
    chk("rst_idx", 32'(idx_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    step(1'b0, '0, '0, 1'b0);
    chk("post_rst_idx", 32'(idx_o), 32'd0);
    chk("post_rst_data", data_o, 32'd0);

    // Full array, yumi held high.
    step(1'b1, seq_a0, 5'b11111, 1'b1);
    for (int k = 0; k < N; k++) step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);

    // Sparse mask.
    step(1'b1, rnd_arr(), 5'b10010, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);

    // Zero mask is discarded; the next array is taken straight away.
    step(1'b1, rnd_arr(), 5'b00000, 1'b0);
    step(1'b1, rnd_arr(), 5'b00001, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);

    // Backpressure on the first beat.
    step(1'b1, rnd_arr(), 5'b00101, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, rnd_arr(), '0, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);

    // Back-to-back: v_i stays high with a changing array throughout.
    step(1'b1, rnd_arr(), 5'b01011, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, rnd_arr(), 5'b11111, 1'b1);
    step(1'b1, rnd_arr(), 5'b10100, 1'b1);
    step(1'b1, rnd_arr(), 5'b11111, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);

    // Reset asserted while beat idx 1 is on offer.
    step(1'b1, seq_a0, 5'b11111, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    yumi_i  = 1'b0;
    reset_i = 1'b1;
    #1;
    q.delete();
    chk("midrst_v", 32'(v_o), 32'd0);
    chk("midrst_ready", 32'(ready_o), 32'd1);
    chk("midrst_idx", 32'(idx_o), 32'd0);
    chk("midrst_data", data_o, 32'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    step(1'b1, rnd_arr(), 5'b01100, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [N-1:0] m;
      m = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      step(1'($urandom_range(0, 1)), rnd_arr(), m, $urandom_range(0, 9) < 7);
    end
    for (int n = 0; n < 20; n++) step(1'b0, '0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
